// File: rtl/vec_exec_pkg.sv
// Shared definitions for the vector execute stage: opcodes, FSM states,
// default geometry and opcode classification helpers.
package vec_exec_pkg;

  localparam int LANE_W_DEF          = 16;
  localparam int NUM_LANES_DEF       = 16;
  localparam int LANES_PER_CYCLE_DEF = 4;

  // Opcode encoding shared with the operand picker
  localparam logic [3:0] OP_VADD = 4'b0000;
  localparam logic [3:0] OP_VDOT = 4'b0001;
  localparam logic [3:0] OP_SMUL = 4'b0010;
  localparam logic [3:0] OP_SST  = 4'b0011;
  localparam logic [3:0] OP_VLD  = 4'b0100;
  localparam logic [3:0] OP_VST  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SLH  = 4'b0111;
  localparam logic [3:0] OP_NOP  = 4'b1111;

  // Lane ALU operation select
  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_MUL = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Multi-cycle ops that walk the lanes
  function automatic logic is_vector_op(input logic [3:0] f);
    return (f == OP_VADD) || (f == OP_VDOT) || (f == OP_SMUL);
  endfunction

  // Everything this stage knows how to execute; SST and 1000-1110 are not
  function automatic logic is_legal_op(input logic [3:0] f);
    return is_vector_op(f) || (f == OP_VLD) || (f == OP_VST) ||
           (f == OP_SLL) || (f == OP_SLH) || (f == OP_NOP);
  endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// One combinational lane: add or multiply, truncated to the lane width.
module vec_lane_alu
  import vec_exec_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF
) (
  input  logic signed [LANE_W-1:0] a,
  input  logic signed [LANE_W-1:0] b,
  input  logic                     sel,
  output logic signed [LANE_W-1:0] y
);

  // Two's complement add or low half of the product
  always_comb begin
    y = (sel == ALU_MUL) ? a * b : a + b;
  end

endmodule

// File: rtl/vector_exec_unit.sv
// Vector execute stage: multi-cycle lane-group walk for VADD/VDOT/SMUL,
// single-cycle scalar ops, start/busy/done handshake toward control.
module vector_exec_unit
  import vec_exec_pkg::*;
#(
  parameter int LANE_W          = LANE_W_DEF,
  parameter int NUM_LANES       = NUM_LANES_DEF,
  parameter int LANES_PER_CYCLE = LANES_PER_CYCLE_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [3:0]                    functype,
  input  logic [NUM_LANES*LANE_W-1:0]   op1,
  input  logic [NUM_LANES*LANE_W-1:0]   op2,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_LANES*LANE_W-1:0]   result,
  output logic                          illegal
);

  localparam int VEC_W  = NUM_LANES * LANE_W;
  localparam int N      = NUM_LANES / LANES_PER_CYCLE;
  localparam int CNT_W  = (N > 1) ? $clog2(N) : 1;
  localparam int HALF_W = LANE_W / 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_t                   state;
  logic [CNT_W-1:0]         cnt;
  logic [3:0]               func_q;
  logic [VEC_W-1:0]         op1_q;
  logic [VEC_W-1:0]         op2_q;
  logic signed [LANE_W-1:0] acc;

  logic signed [LANE_W-1:0] lane_a [LANES_PER_CYCLE];
  logic signed [LANE_W-1:0] lane_b [LANES_PER_CYCLE];
  logic signed [LANE_W-1:0] lane_y [LANES_PER_CYCLE];
  logic                     lane_sel;
  logic signed [LANE_W-1:0] group_sum;
  logic signed [LANE_W-1:0] acc_next;
  logic [VEC_W-1:0]         result_run;
  logic [LANE_W-1:0]        scalar_res;
  logic                     accept;

  assign busy   = (state == ST_RUN);
  assign done   = (state == ST_DONE);
  assign accept = start && (state != ST_RUN);

  // Lane-select muxes: pick the current lane group from the latched operands
  always_comb begin
    lane_sel = (func_q == OP_VADD) ? ALU_ADD : ALU_MUL;
    for (int j = 0; j < LANES_PER_CYCLE; j++) begin
      lane_a[j] = (func_q == OP_SMUL) ? op1_q[LANE_W-1:0]
                : op1_q[(int'(cnt) * LANES_PER_CYCLE + j) * LANE_W +: LANE_W];
      lane_b[j] = op2_q[(int'(cnt) * LANES_PER_CYCLE + j) * LANE_W +: LANE_W];
    end
  end

  for (genvar g = 0; g < LANES_PER_CYCLE; g++) begin : g_lane
    vec_lane_alu #(.LANE_W(LANE_W)) u_alu (
      .a   (lane_a[g]),
      .b   (lane_b[g]),
      .sel (lane_sel),
      .y   (lane_y[g])
    );
  end

  // Merge lane outputs: write-back image for element-wise ops, partial sum for VDOT
  always_comb begin
    group_sum  = '0;
    result_run = result;
    for (int j = 0; j < LANES_PER_CYCLE; j++) begin
      group_sum = group_sum + lane_y[j];
      result_run[(int'(cnt) * LANES_PER_CYCLE + j) * LANE_W +: LANE_W] = lane_y[j];
    end
    acc_next = acc + group_sum;
  end

  // Single-cycle scalar results, computed from the incoming operands at accept
  always_comb begin
    scalar_res = '0;
    case (functype)
      OP_VLD, OP_VST: scalar_res = op1[LANE_W-1:0] + op2[LANE_W-1:0];
      OP_SLL:         scalar_res = {op1[LANE_W-1:HALF_W], op2[HALF_W-1:0]};
      OP_SLH:         scalar_res = {op2[HALF_W-1:0], op1[HALF_W-1:0]};
      default:        scalar_res = '0;
    endcase
  end

  // Control FSM with lane counter, VDOT accumulator and result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      acc     <= '0;
      result  <= '0;
      illegal <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            func_q  <= functype;
            op1_q   <= op1;
            op2_q   <= op2;
            illegal <= 1'b0;
            if (is_vector_op(functype)) begin
              state <= ST_RUN;
              cnt   <= '0;
              acc   <= '0;
            end else begin
              state   <= ST_DONE;
              result  <= {{(VEC_W-LANE_W){1'b0}}, scalar_res};
              illegal <= !is_legal_op(functype);
            end
          end else begin
            state   <= ST_IDLE;
            illegal <= 1'b0;
          end
        end
        ST_RUN: begin
          cnt <= cnt + 1'b1;
          if (func_q == OP_VDOT) acc <= acc_next;
          else                   result <= result_run;
          if (cnt == CNT_LAST) begin
            state <= ST_DONE;
            if (func_q == OP_VDOT) result <= {{(VEC_W-LANE_W){1'b0}}, acc_next};
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_exec_unit.sv
// Directed bench for vector_exec_unit with hand-computed expected values.
module tb_vector_exec_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [3:0]   functype;
  logic [255:0] op1;
  logic [255:0] op2;
  logic         busy;
  logic         done;
  logic [255:0] result;
  logic         illegal;

  int n_vec = 0;
  int n_err = 0;

  vector_exec_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .functype (functype),
    .op1      (op1),
    .op2      (op2),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic check_vec(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] f, input logic [255:0] a, input logic [255:0] b);
    functype = f;
    op1      = a;
    op2      = b;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
  endtask

  logic [255:0] va, vb, ve;
  int           lat;
  int           pulses;

  initial begin
    rst_n = 1'b0; start = 1'b0; functype = 4'b1111; op1 = '0; op2 = '0;
    step(); step();
    check_vec("rst_busy",    256'(busy),    256'(0));
    check_vec("rst_done",    256'(done),    256'(0));
    check_vec("rst_illegal", 256'(illegal), 256'(0));
    check_vec("rst_result",  result,        256'(0));
    rst_n = 1'b1;
    step();

    // Reset during RUN: no done, result cleared
    issue(4'b0000, {16{16'h0001}}, {16{16'h0002}});
    check_vec("midrst_busy_run", 256'(busy), 256'(1));
    step();
    rst_n = 1'b0;
    step();
    check_vec("midrst_busy", 256'(busy), 256'(0));
    check_vec("midrst_result", result, 256'(0));
    pulses = 0;
    if (done) pulses++;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) pulses++;
    end
    check_vec("midrst_no_done", 256'(pulses), 256'(0));

    // VADD wrap: 7FFF + 1 = 8000 in every lane
    issue(4'b0000, {16{16'h7FFF}}, {16{16'h0001}});
    check_vec("vadd_busy", 256'(busy), 256'(1));
    wait_done(lat);
    check_vec("vadd_latency", 256'(lat), 256'(4));
    check_vec("vadd_result", result, {16{16'h8000}});
    check_vec("vadd_illegal", 256'(illegal), 256'(0));
    step();
    check_vec("vadd_done_pulse", 256'(done), 256'(0));

    // VDOT: sum (i+1)*2 over 16 lanes = 272
    for (int i = 0; i < 16; i++) va[i*16 +: 16] = 16'(i + 1);
    vb = {16{16'h0002}};
    issue(4'b0001, va, vb);
    wait_done(lat);
    check_vec("vdot_latency", 256'(lat), 256'(4));
    check_vec("vdot_result", result, 256'(16'd272));

    // SMUL with -1 scalar; op1 upper lanes are junk and must be ignored
    for (int i = 0; i < 16; i++) begin
      va[i*16 +: 16] = 16'h1234;
      vb[i*16 +: 16] = 16'(i);
      ve[i*16 +: 16] = 16'(0 - i);
    end
    va[15:0] = 16'hFFFF;
    issue(4'b0010, va, vb);
    functype = 4'b0000; op1 = {16{16'h5555}}; op2 = {16{16'h1111}}; start = 1'b1;
    step();
    start = 1'b0;
    check_vec("smul_busy_after_drop", 256'(busy), 256'(1));
    wait_done(lat);
    check_vec("smul_latency", 256'(lat + 1), 256'(4));
    check_vec("smul_result", result, ve);
    step();
    check_vec("smul_drop_idle", 256'(busy | done), 256'(0));

    // Scalar ops finish one cycle after the accept edge
    issue(4'b0100, 256'(16'h0100), 256'(16'hFFFE));
    check_vec("vld_done", 256'(done), 256'(1));
    check_vec("vld_result", result, 256'(16'h00FE));
    issue(4'b0101, {16{16'h0003}}, {16{16'h0004}});
    check_vec("vst_result", result, 256'(16'h0007));
    issue(4'b0110, 256'(16'hABCD), 256'(16'h3412));
    check_vec("sll_done", 256'(done), 256'(1));
    check_vec("sll_result", result, 256'(16'hAB12));
    issue(4'b0111, 256'(16'hABCD), 256'(16'h3412));
    check_vec("slh_result", result, 256'(16'h12CD));

    // Unsupported opcodes
    issue(4'b0011, {16{16'hFFFF}}, {16{16'hFFFF}});
    check_vec("sst_done", 256'(done), 256'(1));
    check_vec("sst_illegal", 256'(illegal), 256'(1));
    check_vec("sst_result", result, 256'(0));
    issue(4'b0110, 256'(16'hABCD), 256'(16'h0012));
    check_vec("sll_after_illegal", 256'(illegal), 256'(0));
    issue(4'b1010, {16{16'h1234}}, {16{16'h1234}});
    check_vec("op1010_illegal", 256'(illegal), 256'(1));
    check_vec("op1010_result", result, 256'(0));
    step();
    check_vec("illegal_clears", 256'(illegal | done), 256'(0));

    // Back-to-back NOPs keep done high on consecutive cycles
    issue(4'b0110, 256'(16'hABCD), 256'(16'h0012));
    functype = 4'b1111; start = 1'b1;
    step();
    check_vec("nop1_done", 256'(done), 256'(1));
    check_vec("nop1_result", result, 256'(0));
    step();
    start = 1'b0;
    check_vec("nop2_done", 256'(done), 256'(1));
    check_vec("nop2_illegal", 256'(illegal), 256'(0));
    step();
    check_vec("nop_end", 256'(done), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
